// File: rtl/key_bit_tx_pkg.sv
// key_bit_tx_pkg: shared FSM encoding, bit constants and default debounce length
package key_bit_tx_pkg;
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic BIT_K1 = 1'b1;
  localparam logic BIT_K2 = 1'b0;
  localparam int CLK_HZ = 50_000_000;
  // 20 ms of stable level at the 50 MHz system clock
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 50;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, counter debounce and one-cycle press event
// Ports: clk, rst_n (async active-low), pin (raw key), press (one-cycle pulse per debounced press)
module key_debounce
  import key_bit_tx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = 20,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic press
);
  localparam logic REL = KEY_ACTIVE_LOW != 0;
  logic s1, s2, db, db_q, diff, done;
  logic [CNT_W-1:0] cnt;
  assign diff = s2 != db;
  assign done = diff && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= REL;
      s2 <= REL;
      db <= REL;
      db_q <= REL;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      cnt <= (diff && !done) ? cnt + 1'b1 : '0;
      if (done) db <= s2;
      db_q <= db;
      // registered edge detect: fires the cycle after the debounced level turns pressed
      press <= db != REL && db_q == REL;
    end
endmodule

// File: rtl/key_bit_tx.sv
// key_bit_tx: debounced two-key bit source with valid/ready output, drop pulse and event counter
// Ports: CLOCK_50, rst_n (async active-low), k1/k2 (raw keys, 1/0), bit_ready (core accept),
//        bit_valid/bit_value (pending bit), drop_pulse (discarded press), evt_count (accepted presses)
module key_bit_tx
  import key_bit_tx_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = 20,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       k1,
  input  logic       k2,
  input  logic       bit_ready,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       drop_pulse,
  output logic [7:0] evt_count
);
  state_t state, state_n;
  logic ev1, ev0, xfer, one, acc, value_n, drop_n;
  logic [7:0] count_n;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_k1 (.clk(CLOCK_50), .rst_n(rst_n), .pin(k1), .press(ev1));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW))
    u_k2 (.clk(CLOCK_50), .rst_n(rst_n), .pin(k2), .press(ev0));
  assign bit_valid = state == PEND;
  // a lone event is taken when the slot is free now or is being freed on this edge;
  // simultaneous events are always dropped together
  always_comb begin
    xfer = state == PEND && bit_ready;
    one = ev1 ^ ev0;
    acc = one && (state == IDLE || xfer);
    state_n = acc ? PEND : xfer ? IDLE : state;
    value_n = acc ? (ev1 ? BIT_K1 : BIT_K2) : bit_value;
    count_n = evt_count + 8'(acc);
    drop_n = (ev1 && ev0) || (one && !acc);
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_value <= 1'b0;
      drop_pulse <= 1'b0;
      evt_count <= '0;
    end else begin
      state <= state_n;
      bit_value <= value_n;
      drop_pulse <= drop_n;
      evt_count <= count_n;
    end
endmodule

// File: tb/tb_key_bit_tx.sv
// tb_key_bit_tx: directed plan plus randomized key/ready stimulus against a window-based reference model
module tb_key_bit_tx;
  localparam int DC = 4;
  logic CLOCK_50 = 1'b0, rst_n = 1'b0, k1 = 1'b1, k2 = 1'b1, bit_ready = 1'b0;
  logic bit_valid, bit_value, drop_pulse;
  logic [7:0] evt_count;
  int passed = 0, total = 0, drops = 0, h1 = 1, h2 = 1;
  bit hist1[$], hist2[$];
  bit db1, db2, m_valid, m_val, m_drop;
  bit [1:0] p1, p2;
  logic [7:0] m_cnt;

  key_bit_tx #(.DEBOUNCE_CYCLES(DC), .CNT_W(3), .KEY_ACTIVE_LOW(1)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .k1(k1), .k2(k2), .bit_ready(bit_ready),
    .bit_valid(bit_valid), .bit_value(bit_value), .drop_pulse(drop_pulse), .evt_count(evt_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist1.delete(); hist2.delete();
    db1 = 0; db2 = 0; p1 = 0; p2 = 0;
    m_valid = 0; m_val = 0; m_drop = 0; m_cnt = 0; drops = 0;
  endtask

  // A key's debounced level flips at edge n when the DC pin samples taken at
  // edges n-DC-1 .. n-2 all disagree with it; a press reaches the FSM two edges later.
  task automatic model_edge();
    bit f1, f2, e1, e0, x;
    int n;
    hist1.push_back(!k1);
    hist2.push_back(!k2);
    n = hist1.size() - 1;
    f1 = n >= DC + 1;
    f2 = f1;
    for (int i = n - DC - 1; i <= n - 2; i++)
      if (i >= 0) begin
        if (hist1[i] == db1) f1 = 0;
        if (hist2[i] == db2) f2 = 0;
      end
    if (f1) db1 = !db1;
    if (f2) db2 = !db2;
    e1 = p1[1]; p1 = {p1[0], f1 && db1};
    e0 = p2[1]; p2 = {p2[0], f2 && db2};
    x = m_valid && bit_ready;
    m_drop = 0;
    if (e1 && e0) begin
      m_drop = 1;
      if (x) m_valid = 0;
    end else if (e1 || e0) begin
      if (!m_valid || x) begin
        m_val = e1; m_valid = 1; m_cnt = m_cnt + 8'd1;
      end else m_drop = 1;
    end else if (x) m_valid = 0;
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    if (drop_pulse) drops++;
    check("valid", bit_valid, m_valid);
    check("value", bit_value, m_val);
    check("drop", drop_pulse, m_drop);
    check("count", evt_count, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_valid", bit_valid, 0);
    check("rst_value", bit_value, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_count", evt_count, 0);
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !bit_valid; i++) step();
    check("wait_valid_timeout", bit_valid, 1);
  endtask

  initial begin
    // 1: single press, latency DC+3 and hold without ready
    k1 = 1; k2 = 1; bit_ready = 0;
    do_reset();
    k1 = 0;
    repeat (7) step();
    check("t1_not_yet", bit_valid, 0);
    step();
    check("t1_valid", bit_valid, 1);
    check("t1_value", bit_value, 1);
    check("t1_count", evt_count, 1);
    repeat (5) step();
    check("t1_hold", bit_valid, 1);
    // 2: glitches shorter than the debounce window
    k1 = 1;
    do_reset();
    repeat (5) begin
      k2 = 0; repeat (3) step();
      k2 = 1; repeat (3) step();
    end
    check("t2_valid", bit_valid, 0);
    check("t2_count", evt_count, 0);
    check("t2_drops", drops, 0);
    // 3: handshake
    do_reset();
    k2 = 0;
    wait_valid(20);
    step();
    bit_ready = 1;
    step();
    bit_ready = 0;
    check("t3_valid", bit_valid, 0);
    check("t3_value", bit_value, 0);
    check("t3_count", evt_count, 1);
    k2 = 1;
    // 4: overrun
    do_reset();
    k1 = 0;
    wait_valid(20);
    k1 = 1;
    repeat (8) step();
    k2 = 0;
    repeat (10) step();
    check("t4_drops", drops, 1);
    check("t4_value", bit_value, 1);
    check("t4_count", evt_count, 1);
    k2 = 1;
    // 5: collision
    do_reset();
    k1 = 0; k2 = 0;
    repeat (10) step();
    check("t5_drops", drops, 1);
    check("t5_valid", bit_valid, 0);
    check("t5_count", evt_count, 0);
    k2 = 1;
    // 6: reset while pending, key held through release
    do_reset();
    k1 = 0;
    wait_valid(20);
    step();
    do_reset();
    repeat (7) step();
    check("t6_not_yet", bit_valid, 0);
    step();
    check("t6_valid", bit_valid, 1);
    check("t6_value", bit_value, 1);
    check("t6_count", evt_count, 1);
    // randomized keys and ready
    k1 = 1; k2 = 1;
    do_reset();
    repeat (1500) begin
      if (--h1 == 0) begin k1 = 1'($urandom_range(0, 1)); h1 = $urandom_range(1, 12); end
      if (--h2 == 0) begin k2 = 1'($urandom_range(0, 1)); h2 = $urandom_range(1, 12); end
      bit_ready = $urandom_range(0, 3) == 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
